// File: rtl/cycle_meas_ctrl.sv
// Start/stop edge cycle counter with timeout, saturation and result handshake.
// Optional min/max/count statistics when CYCLE_MEAS_STATS_EN is defined.
module cycle_meas_ctrl #(
  parameter int COUNTER_SIZE    = 40,
  parameter int STAT_COUNT_SIZE = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    arm_i,
  input  logic                    abort_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [COUNTER_SIZE-1:0] timeout_i,
  input  logic                    result_ack_i,
  output logic                    busy_o,
  output logic [COUNTER_SIZE-1:0] count_o,
  output logic [COUNTER_SIZE-1:0] result_o,
  output logic                    result_valid_o,
  output logic                    timeout_o,
  output logic                    overflow_o
`ifdef CYCLE_MEAS_STATS_EN
  ,
  output logic [COUNTER_SIZE-1:0]    min_o,
  output logic [COUNTER_SIZE-1:0]    max_o,
  output logic [STAT_COUNT_SIZE-1:0] meas_num_o
`endif
);

  typedef enum logic [1:0] {
    IDLE, ARMED, RUN, DONE
  } state_t;

  localparam logic [COUNTER_SIZE-1:0] CNT_MAX = '1;

  state_t state_q, state_d;
  logic [COUNTER_SIZE-1:0] count_q, count_d;
  logic [COUNTER_SIZE-1:0] result_q, result_d;
  logic tmo_q, tmo_d;
  logic ovf_q, ovf_d;
  logic start_prev_q, stop_prev_q;
  logic start_edge, stop_edge;
  logic stop_cap;

  assign start_edge = start_i & ~start_prev_q;
  assign stop_edge  = stop_i & ~stop_prev_q;

`ifdef CYCLE_MEAS_STATS_EN
  localparam logic [STAT_COUNT_SIZE-1:0] NUM_MAX = '1;
  logic [COUNTER_SIZE-1:0] min_q, min_d, max_q, max_d;
  logic [STAT_COUNT_SIZE-1:0] num_q, num_d;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      count_q      <= '0;
      result_q     <= '0;
      tmo_q        <= 1'b0;
      ovf_q        <= 1'b0;
      // History at 1 so a trigger already high is not seen as an edge
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
`ifdef CYCLE_MEAS_STATS_EN
      min_q        <= '1;
      max_q        <= '0;
      num_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      result_q     <= result_d;
      tmo_q        <= tmo_d;
      ovf_q        <= ovf_d;
      start_prev_q <= start_i;
      stop_prev_q  <= stop_i;
`ifdef CYCLE_MEAS_STATS_EN
      min_q        <= min_d;
      max_q        <= max_d;
      num_q        <= num_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    tmo_d    = tmo_q;
    ovf_d    = ovf_q;
    stop_cap = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d = ARMED;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        if (abort_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (start_edge) begin
          state_d = RUN;
          count_d = COUNTER_SIZE'(1);
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (stop_edge) begin
          state_d  = DONE;
          result_d = count_q;
          tmo_d    = 1'b0;
          stop_cap = 1'b1;
        end else if (timeout_i != '0 && count_q == timeout_i) begin
          state_d  = DONE;
          result_d = count_q;
          tmo_d    = 1'b1;
        end else if (count_q != CNT_MAX) begin
          count_d = count_q + 1'b1;
          if (count_q == CNT_MAX - 1'b1) ovf_d = 1'b1;
        end
      end
      DONE: begin
        if (result_ack_i) begin
          if (arm_i) begin
            state_d = ARMED;
            count_d = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CYCLE_MEAS_STATS_EN
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    num_d = num_q;
    if (stop_cap && !ovf_q) begin
      if (count_q < min_q) min_d = count_q;
      if (count_q > max_q) max_d = count_q;
      if (num_q != NUM_MAX) num_d = num_q + 1'b1;
    end
  end

  assign min_o      = min_q;
  assign max_o      = max_q;
  assign meas_num_o = num_q;
`endif

  always_comb begin
    busy_o         = (state_q == ARMED) || (state_q == RUN);
    result_valid_o = (state_q == DONE);
    count_o        = count_q;
    result_o       = result_q;
    timeout_o      = tmo_q;
    overflow_o     = ovf_q;
  end

endmodule

// File: tb/tb_cycle_meas_ctrl.sv
// Directed bench for cycle_meas_ctrl: a 40-bit and a 4-bit instance
// share stimulus; stats checks are built when CYCLE_MEAS_STATS_EN is set.
module tb_cycle_meas_ctrl;

  logic clk = 1'b0;
  logic rst, arm, abort, start, stop, ack;
  logic [39:0] tmo_b;
  logic [3:0]  tmo_s;
  logic        busy_b, vld_b, to_b, ovf_b;
  logic [39:0] cnt_b, res_b;
  logic        busy_s, vld_s, to_s, ovf_s;
  logic [3:0]  cnt_s, res_s;
`ifdef CYCLE_MEAS_STATS_EN
  logic [39:0] min_b, max_b;
  logic [15:0] num_b;
  logic [3:0]  min_s, max_s;
  logic [15:0] num_s;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cycle_meas_ctrl #(.COUNTER_SIZE(40)) u_big (
    .clock_i(clk), .reset_i(rst), .arm_i(arm), .abort_i(abort),
    .start_i(start), .stop_i(stop), .timeout_i(tmo_b),
    .result_ack_i(ack), .busy_o(busy_b), .count_o(cnt_b),
    .result_o(res_b), .result_valid_o(vld_b),
    .timeout_o(to_b), .overflow_o(ovf_b)
`ifdef CYCLE_MEAS_STATS_EN
    , .min_o(min_b), .max_o(max_b), .meas_num_o(num_b)
`endif
  );

  cycle_meas_ctrl #(.COUNTER_SIZE(4)) u_small (
    .clock_i(clk), .reset_i(rst), .arm_i(arm), .abort_i(abort),
    .start_i(start), .stop_i(stop), .timeout_i(tmo_s),
    .result_ack_i(ack), .busy_o(busy_s), .count_o(cnt_s),
    .result_o(res_s), .result_valid_o(vld_s),
    .timeout_o(to_s), .overflow_o(ovf_s)
`ifdef CYCLE_MEAS_STATS_EN
    , .min_o(min_s), .max_o(max_s), .meas_num_o(num_s)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arm = 1'b0; abort = 1'b0; stop = 1'b0; ack = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1; step(); ack = 1'b0;
    start = 1'b0; stop = 1'b0; step();
  endtask

  task automatic run_meas(input int n);
    arm = 1'b1; step(); arm = 1'b0;
    start = 1'b1; step();
    repeat (n - 1) step();
    stop = 1'b1; step();
    do_ack();
  endtask

  int  n;
  logic wrap;

  initial begin
    start = 1'b0;
    tmo_b = '0;
    tmo_s = '0;
    do_reset();

    // Basic measurement, 25 cycles
    check("rst_busy", busy_b, 0);
    check("rst_cnt", cnt_b, 0);
    check("rst_vld", vld_b, 0);
    check("rst_res", res_b, 0);
    check("rst_ovf", ovf_b, 0);
    arm = 1'b1; step(); arm = 1'b0;
    check("armed_busy", busy_b, 1);
    repeat (3) step();
    check("armed_cnt", cnt_b, 0);
    start = 1'b1; step();
    check("run_cnt1", cnt_b, 1);
    repeat (24) step();
    check("run_cnt25", cnt_b, 25);
    stop = 1'b1; step();
    check("b_vld", vld_b, 1);
    check("b_res", res_b, 25);
    check("b_to", to_b, 0);
    check("b_busy", busy_b, 0);
    repeat (5) step();
    check("b_hold_vld", vld_b, 1);
    check("b_hold_res", res_b, 25);
    check("b_hold_cnt", cnt_b, 25);
    ack = 1'b1; step(); ack = 1'b0;
    check("b_ack_vld", vld_b, 0);
    check("b_ack_busy", busy_b, 0);
    start = 1'b0; stop = 1'b0; step();

    // Timeout at 100, then stop coinciding with timeout
    tmo_b = 40'd100;
    arm = 1'b1; step(); arm = 1'b0;
    start = 1'b1;
    n = 0;
    while (!vld_b && n < 200) begin
      step(); n++;
    end
    check("to_lat", n, 101);
    check("to_res", res_b, 100);
    check("to_flag", to_b, 1);
    do_ack();
    arm = 1'b1; step(); arm = 1'b0;
    start = 1'b1; step();
    repeat (99) step();
    check("to2_cnt", cnt_b, 100);
    stop = 1'b1; step();
    check("to2_vld", vld_b, 1);
    check("to2_res", res_b, 100);
    check("to2_flag", to_b, 0);
    do_ack();

    // 4-bit saturation
    tmo_b = '0;
    start = 1'b0;
    do_reset();
    arm = 1'b1; step(); arm = 1'b0;
    start = 1'b1; step();
    repeat (13) step();
    check("s_cnt14", cnt_s, 14);
    check("s_ovf0", ovf_s, 0);
    step();
    check("s_cnt15", cnt_s, 15);
    check("s_ovf1", ovf_s, 1);
    wrap = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cnt_s != 4'd15) wrap = 1'b1;
    end
    check("s_nowrap", wrap, 0);
    stop = 1'b1; step();
    check("s_vld", vld_s, 1);
    check("s_res", res_s, 15);
    check("s_ovf_res", ovf_s, 1);
    check("b_no_ovf", ovf_b, 0);

    // Start held through reset; start+stop edge together
    start = 1'b1;
    do_reset();
    arm = 1'b1; step(); arm = 1'b0;
    repeat (3) step();
    check("hi_busy", busy_b, 1);
    check("hi_cnt", cnt_b, 0);
    start = 1'b0; step();
    start = 1'b1; stop = 1'b1; step();
    check("ss_cnt", cnt_b, 1);
    check("ss_novld", vld_b, 0);
    repeat (3) step();
    check("ss_cnt4", cnt_b, 4);
    stop = 1'b0; step();
    stop = 1'b1; step();
    check("ss_vld", vld_b, 1);
    check("ss_res", res_b, 5);
    do_ack();

    // Abort at count 7; arm with ack in DONE
    arm = 1'b1; step(); arm = 1'b0;
    start = 1'b1; step();
    repeat (6) step();
    check("ab_cnt7", cnt_b, 7);
    abort = 1'b1; step(); abort = 1'b0;
    check("ab_busy", busy_b, 0);
    check("ab_vld", vld_b, 0);
    check("ab_cnt", cnt_b, 0);
    repeat (2) step();
    check("ab_vld2", vld_b, 0);
    start = 1'b0; step();
    arm = 1'b1; step(); arm = 1'b0;
    start = 1'b1; step();
    repeat (2) step();
    stop = 1'b1; step();
    check("bb_res", res_b, 3);
    arm = 1'b1; step();
    check("bb_noack_vld", vld_b, 1);
    ack = 1'b1; step(); arm = 1'b0; ack = 1'b0;
    check("bb_busy", busy_b, 1);
    check("bb_vld", vld_b, 0);
    check("bb_cnt", cnt_b, 0);

`ifdef CYCLE_MEAS_STATS_EN
    start = 1'b0;
    do_reset();
    check("st_min_rst", min_b, 40'hFF_FFFF_FFFF);
    check("st_num_rst", num_b, 0);
    run_meas(12);
    run_meas(5);
    run_meas(30);
    tmo_b = 40'd8;
    arm = 1'b1; step(); arm = 1'b0;
    start = 1'b1;
    repeat (20) step();
    check("st_to", to_b, 1);
    do_ack();
    check("st_min", min_b, 5);
    check("st_max", max_b, 30);
    check("st_num", num_b, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
